// File: rtl/issue_scoreboard_pkg.sv
// Shared types and sizing for the issue scoreboard slice.
// Optional writeback bypass is selected with ISSUE_SB_WB_BYPASS_EN (see reg_scoreboard).
package issue_scoreboard_pkg;
  localparam int XLEN        = 32;
  localparam int NUM_REGS    = 32;
  localparam int REG_W       = $clog2(NUM_REGS);
  localparam int PAYLOAD_W   = 96;
  localparam int STALL_CNT_W = 16;

  typedef enum logic {
    SB_EMPTY = 1'b0,
    SB_HOLD  = 1'b1
  } SB_state_t;
endpackage

// File: rtl/issue_scoreboard_if.sv
// Decoder-side, execute-side, writeback and flush signals of the issue scoreboard.
// slave = the scoreboard, master = the surrounding pipeline.
interface issue_scoreboard_if import issue_scoreboard_pkg::*; ();
  logic                 de_valid;
  logic                 de_ready;
  logic [PAYLOAD_W-1:0] de_payload;
  logic [REG_W-1:0]     de_rs1;
  logic [REG_W-1:0]     de_rs2;
  logic [REG_W-1:0]     de_rd;
  logic                 de_rs1_used;
  logic                 de_rs2_used;
  logic                 de_rd_used;
  logic                 ex_valid;
  logic                 ex_ready;
  logic [PAYLOAD_W-1:0] ex_payload;
  logic                 wb_valid;
  logic [REG_W-1:0]     wb_rd;
  logic                 flush;

  modport master (
    output de_valid, de_payload, de_rs1, de_rs2, de_rd,
           de_rs1_used, de_rs2_used, de_rd_used,
           ex_ready, wb_valid, wb_rd, flush,
    input  de_ready, ex_valid, ex_payload
  );

  modport slave (
    input  de_valid, de_payload, de_rs1, de_rs2, de_rd,
           de_rs1_used, de_rs2_used, de_rd_used,
           ex_ready, wb_valid, wb_rd, flush,
    output de_ready, ex_valid, ex_payload
  );
endinterface

// File: rtl/issue_scoreboard_reg_scoreboard.sv
// Busy-bit vector with one set port, one clear port and three read ports.
// ISSUE_SB_WB_BYPASS_EN: read ports see the same-cycle writeback clear.
module reg_scoreboard import issue_scoreboard_pkg::*; (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                set_en,
  input  logic [REG_W-1:0]    set_idx,
  input  logic                clr_en,
  input  logic [REG_W-1:0]    clr_idx,
  input  logic [REG_W-1:0]    rs1_idx,
  input  logic [REG_W-1:0]    rs2_idx,
  input  logic [REG_W-1:0]    rd_idx,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                rd_busy,
  output logic [NUM_REGS-1:0] busy
);
  logic [NUM_REGS-1:0] busy_q, busy_d, busy_eff, set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    // set is applied after clear so a same-cycle reissue of a register stays busy
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

`ifdef ISSUE_SB_WB_BYPASS_EN
  assign busy_eff = busy_q & ~clr_mask;
`else
  assign busy_eff = busy_q;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign rs1_busy = busy_eff[rs1_idx];
  assign rs2_busy = busy_eff[rs2_idx];
  assign rd_busy  = busy_eff[rd_idx];
  assign busy     = busy_q;
endmodule

// File: rtl/issue_scoreboard.sv
// Single-entry issue stage: holds one decoded instruction and releases it when free of RAW/WAW hazards.
// Build option ISSUE_SB_WB_BYPASS_EN lets a writeback resolve a hazard in its own cycle.
//   state    | meaning
//   SB_EMPTY | no instruction held, decoder always accepted
//   SB_HOLD  | one instruction held, offered to execute when hazard-free
module issue_scoreboard import issue_scoreboard_pkg::*; (
  input  logic                   i_clk,
  input  logic                   i_reset,
  issue_scoreboard_if.slave      sb,
  output logic [NUM_REGS-1:0]    o_busy,
  output logic [STALL_CNT_W-1:0] o_stall_count,
  output SB_state_t              o_state
);
  SB_state_t            state_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [REG_W-1:0]     rs1_q, rs2_q, rd_q;
  logic                 rs1_used_q, rs2_used_q, rd_used_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic rs1_busy, rs2_busy, rd_busy;
  logic hold, hazard, ex_valid, issue, de_ready, accept;

  reg_scoreboard u_reg_scoreboard (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .set_en   (issue & rd_used_q & (rd_q != '0)),
    .set_idx  (rd_q),
    .clr_en   (sb.wb_valid),
    .clr_idx  (sb.wb_rd),
    .rs1_idx  (rs1_q),
    .rs2_idx  (rs2_q),
    .rd_idx   (rd_q),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .busy     (o_busy)
  );

  assign hold     = (state_q == SB_HOLD);
  assign hazard   = (rs1_used_q & rs1_busy) | (rs2_used_q & rs2_busy) | (rd_used_q & rd_busy);
  assign ex_valid = hold & ~hazard & ~sb.flush;
  assign issue    = ex_valid & sb.ex_ready;
  assign de_ready = ~hold | issue | sb.flush;
  assign accept   = sb.de_valid & de_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= SB_EMPTY;
      payload_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_used_q  <= 1'b0;
      rs2_used_q  <= 1'b0;
      rd_used_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) begin
        state_q    <= SB_HOLD;
        payload_q  <= sb.de_payload;
        rs1_q      <= sb.de_rs1;
        rs2_q      <= sb.de_rs2;
        rd_q       <= sb.de_rd;
        rs1_used_q <= sb.de_rs1_used;
        rs2_used_q <= sb.de_rs2_used;
        rd_used_q  <= sb.de_rd_used;
      end else if (issue | sb.flush) begin
        state_q <= SB_EMPTY;
      end
      if (hold & hazard & ~(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign sb.ex_valid   = ex_valid;
  assign sb.de_ready   = de_ready;
  assign sb.ex_payload = payload_q;
  assign o_stall_count = stall_cnt_q;
  assign o_state       = state_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard; expectations follow ISSUE_SB_WB_BYPASS_EN.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

`ifdef ISSUE_SB_WB_BYPASS_EN
  localparam int CNT3 = 1;
`else
  localparam int CNT3 = 2;
`endif

  logic i_clk, i_reset;
  logic [NUM_REGS-1:0]    o_busy;
  logic [STALL_CNT_W-1:0] o_stall_count;
  SB_state_t              o_state;
  int n_chk, n_pass;

  issue_scoreboard_if sb_if ();

  issue_scoreboard dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .sb            (sb_if.slave),
    .o_busy        (o_busy),
    .o_stall_count (o_stall_count),
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [PAYLOAD_W-1:0] mk(input int n);
    return {32'(n), 32'hC0DE0000 | 32'(n), 32'(n * 3 + 7)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic de(input logic v, input int p,
                    input logic [REG_W-1:0] rs1, input logic u1,
                    input logic [REG_W-1:0] rs2, input logic u2,
                    input logic [REG_W-1:0] rd,  input logic ud);
    sb_if.de_valid    = v;
    sb_if.de_payload  = mk(p);
    sb_if.de_rs1      = rs1;
    sb_if.de_rs1_used = u1;
    sb_if.de_rs2      = rs2;
    sb_if.de_rs2_used = u2;
    sb_if.de_rd       = rd;
    sb_if.de_rd_used  = ud;
  endtask

  task automatic de_idle();
    de(1'b0, 0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    i_clk = 1'b0;
    i_reset = 1'b1;
    de_idle();
    sb_if.ex_ready = 1'b1;
    sb_if.wb_valid = 1'b0;
    sb_if.wb_rd    = '0;
    sb_if.flush    = 1'b0;
    #12;
    chk("rst_state", o_state, SB_EMPTY);
    chk("rst_busy", o_busy, 0);
    chk("rst_exv", sb_if.ex_valid, 0);
    chk("rst_cnt", o_stall_count, 0);
    chk("rst_dready", sb_if.de_ready, 1);
    i_reset = 1'b0;

    // back-to-back independent writers x1, x2
    cyc(); de(1, 1, 10, 1, 11, 1, 1, 1); #1;
    chk("t2_dready", sb_if.de_ready, 1);
    cyc(); de(1, 2, 12, 1, 13, 1, 2, 1); #1;
    chk("t2_exv1", sb_if.ex_valid, 1);
    chk("t2_pay1", sb_if.ex_payload, mk(1));
    chk("t2_dready1", sb_if.de_ready, 1);
    cyc(); de_idle(); #1;
    chk("t2_exv2", sb_if.ex_valid, 1);
    chk("t2_pay2", sb_if.ex_payload, mk(2));
    chk("t2_busy1", o_busy, 32'h2);
    cyc(); #1;
    chk("t2_busy12", o_busy, 32'h6);
    chk("t2_empty", o_state, SB_EMPTY);
    chk("t2_exv0", sb_if.ex_valid, 0);

    // writeback to a register that is not busy changes nothing
    sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd20;
    cyc(); sb_if.wb_valid = 1'b0; #1;
    chk("wb_ignore", o_busy, 32'h6);

    // RAW on x3
    de(1, 3, 0, 0, 0, 0, 3, 1);
    cyc(); de(1, 4, 3, 1, 0, 0, 8, 1); #1;
    chk("t3_exv_w", sb_if.ex_valid, 1);
    cyc(); de_idle(); #1;
    chk("t3_haz", sb_if.ex_valid, 0);
    chk("t3_busy", o_busy, 32'hE);
    chk("t3_dready", sb_if.de_ready, 0);
    cyc(); #1;
    chk("t3_cnt1", o_stall_count, 1);
    sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd3; #1;
`ifdef ISSUE_SB_WB_BYPASS_EN
    chk("t3_bypass_exv", sb_if.ex_valid, 1);
    cyc(); sb_if.wb_valid = 1'b0; #1;
    chk("t3_done", o_state, SB_EMPTY);
`else
    chk("t3_nobyp_exv", sb_if.ex_valid, 0);
    cyc(); sb_if.wb_valid = 1'b0; #1;
    chk("t3_exv_late", sb_if.ex_valid, 1);
    cyc(); #1;
    chk("t3_done", o_state, SB_EMPTY);
`endif
    chk("t3_cnt", o_stall_count, CNT3);
    chk("t3_busy_end", o_busy, 32'h106);

    // writer to x0 never marks busy; reader of x0 never stalls
    de(1, 5, 0, 0, 0, 0, 0, 1);
    cyc(); de(1, 6, 0, 1, 0, 1, 0, 0); #1;
    chk("t4_exv_w", sb_if.ex_valid, 1);
    cyc(); de_idle(); #1;
    chk("t4_exv_r", sb_if.ex_valid, 1);
    chk("t4_pay", sb_if.ex_payload, mk(6));
    chk("t4_busy", o_busy, 32'h106);
    cyc(); #1;
    chk("t4_cnt", o_stall_count, CNT3);
    chk("t4_empty", o_state, SB_EMPTY);

    // flush of a reader stalled on x7, new entry captured same cycle
    de(1, 7, 0, 0, 0, 0, 7, 1);
    cyc(); de(1, 8, 0, 0, 7, 1, 0, 0);
    cyc(); de_idle(); #1;
    chk("t5_stall", sb_if.ex_valid, 0);
    chk("t5_busy", o_busy, 32'h186);
    cyc();
    sb_if.flush = 1'b1;
    de(1, 9, 12, 1, 0, 0, 0, 0); #1;
    chk("t5_fl_exv", sb_if.ex_valid, 0);
    chk("t5_fl_dready", sb_if.de_ready, 1);
    cyc();
    sb_if.flush = 1'b0;
    de(1, 10, 13, 1, 0, 0, 0, 0);
    sb_if.ex_ready = 1'b0; #1;
    chk("t5_state", o_state, SB_HOLD);
    chk("t5_pay", sb_if.ex_payload, mk(9));
    chk("t5_busy7", o_busy, 32'h186);
    chk("t5_cnt", o_stall_count, CNT3 + 2);

    // execute back-pressure for 4 cycles
    for (int i = 0; i < 4; i++) begin
      chk("t6_pay", sb_if.ex_payload, mk(9));
      chk("t6_dready", sb_if.de_ready, 0);
      chk("t6_exv", sb_if.ex_valid, 1);
      chk("t6_cnt", o_stall_count, CNT3 + 2);
      cyc(); #1;
    end
    sb_if.ex_ready = 1'b1; #1;
    chk("t6_dready_go", sb_if.de_ready, 1);
    cyc(); de_idle(); #1;
    chk("t6_pay_next", sb_if.ex_payload, mk(10));
    chk("t6_exv_next", sb_if.ex_valid, 1);
    cyc(); #1;
    chk("t6_empty", o_state, SB_EMPTY);

    // async reset while holding a stalled reader of x5
    de(1, 11, 0, 0, 0, 0, 5, 1);
    cyc(); de(1, 12, 5, 1, 0, 0, 0, 0);
    cyc(); de_idle(); #1;
    chk("t1_busy5", o_busy, 32'h1A6);
    chk("t1_hold", o_state, SB_HOLD);
    i_reset = 1'b1; #1;
    chk("t1_state", o_state, SB_EMPTY);
    chk("t1_busy", o_busy, 0);
    chk("t1_exv", sb_if.ex_valid, 0);
    chk("t1_cnt", o_stall_count, 0);
    #2 i_reset = 1'b0;
    cyc(); #1;
    chk("t1_after", o_state, SB_EMPTY);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
